pulse_shaper: RTL and testbench
===============================

# pulse_shaper

Downstream consumer of the clock-synchronous pulse generator. Detects rising edges on the incoming `trig` level and turns each accepted edge into one output pulse exactly `WIDTH` clock cycles wide, followed by a `GAP`-cycle recovery window. Edges arriving while busy are rejected and flagged. Accepted pulses are counted.

## Interface
- `WIDTH`, 5: high time of `pulse` in clock cycles; legal range ≥ 1.
- `GAP`, 2: forced low time after each pulse, in clock cycles; legal range ≥ 0.
- `CNT_W`, 8: width of the accepted-pulse counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  when 1, new edges may start a pulse; when 0, edges are ignored (not flagged).
- `trig`  in  1  trigger level from the upstream pulse generator.
- `clr`  in  1  synchronous clear of `count` and `overrun`.
- `pulse`  out  1  shaped output pulse (registered).
- `busy`  out  1  1 whenever the state is not IDLE.
- `overrun`  out  1  sticky; set when an edge arrives while busy.
- `count`  out  CNT_W  number of pulses started, modulo 2^CNT_W.

## Operation
- Edge detect: register `trig_q` ← `trig` every cycle. An edge is `trig & ~trig_q` sampled at a clock edge.
- States:
  - IDLE: `pulse`=0. On an edge with `en`=1: go to HIGH, `pulse`←1, load the width counter with WIDTH−1, and `count`←`count`+1 (wraps to 0).
  - HIGH: `pulse`=1. The width counter decrements each cycle. At 0, `pulse`←0. If GAP>0, go to GAP and load the gap counter with GAP−1. If GAP=0, go to IDLE.
  - GAP: `pulse`=0. The gap counter decrements each cycle. At 0, go to IDLE.
- Edge in HIGH or GAP: no new pulse, and `overrun`←1 if `en`=1. No queuing.
- `en` falling during HIGH or GAP: the current pulse and gap complete normally. There is no truncation.
- `clr`: `count`←0 and `overrun`←0.
  - If a pulse starts in the same cycle as `clr`, `count`←1.
  - If an overrun is detected in the same cycle as `clr`, `overrun` stays 1 (set wins).
- `clr` does not affect the state, `pulse`, or the counters.
- Reset (asynchronous, `rst`=1):
  - State = IDLE.
  - `pulse`=0, `busy`=0, `overrun`=0, `count`=0, internal counters = 0.
  - `trig_q`=1, so a `trig` held high through reset release is not taken as an edge.

## Timing
- Latency: `trig` sampled high at clock edge k (with `trig_q`=0) → `pulse` is 1 from edge k to edge k+WIDTH. That is exactly WIDTH cycles.
- `busy` rises at edge k and falls at edge k+WIDTH+GAP.
- The earliest next accepted edge is sampled at k+WIDTH+GAP. Minimum pulse-to-pulse spacing is WIDTH+GAP cycles.
- `count` updates at edge k, coincident with the rise of `pulse`.
- `overrun` updates at the edge where the rejected `trig` edge is sampled.
- `rst` asserted mid-pulse: `pulse` and `busy` drop immediately (asynchronously). After release, the block accepts only a fresh 0→1 transition of `trig`.
- A `trig` level held high produces a single pulse. A new pulse requires `trig` to go low for at least one sampled cycle and then high again.

## Test plan
- Reset: `rst`=1 with `trig`=1, then release with `trig` held high → `pulse`, `busy`, `overrun` and `count` stay 0 indefinitely.
- Single pulse (WIDTH=5, GAP=2): `trig` 0→1 sampled at edge 10 → `pulse` high on edges 10–14 and low at 15; `busy` low at 17; `count`=1.
- Overrun and recovery: second `trig` edge sampled at edge 12 (during HIGH) → no extra pulse, `overrun`=1, `count` stays 1. Third edge at edge 17 → accepted, `count`=2, `overrun` still 1.
- Clear collision: `clr`=1 in the same cycle as a new accepted edge → `count`=1. `clr`=1 in the same cycle as a rejected edge → `overrun` remains 1. A later `clr` alone → `overrun`=0.
- Enable and wrap: `en`=0 with 3 `trig` edges → no pulses and no overrun. Then `en`=1, drop `en` mid-pulse → pulse still 5 cycles wide. With CNT_W=2, 5 accepted pulses → `count` reads 1.
- Async reset mid-pulse: `rst` asserted 2 cycles into HIGH → `pulse`=0 before the next clock edge. After release, the next clean `trig` edge gives a full 5-cycle pulse.

Source files
------------

// File: rtl/pulse_shaper.sv
// pulse_shaper: turns accepted trig rising edges into WIDTH-cycle pulses
// followed by a GAP-cycle recovery window, with overrun flag and counter.
module pulse_shaper #(
    parameter int WIDTH = 5,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trig,
    input  logic             clr,
    output logic             pulse,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] count
);

    localparam int WCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam bit HAS_GAP = (GAP > 0);
    localparam logic [WCW-1:0] WLOAD = WCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GLOAD = HAS_GAP ? GCW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WCW-1:0]   wcnt, wcnt_n;
    logic [GCW-1:0]   gcnt, gcnt_n;
    logic             pulse_n;
    logic             overrun_n;
    logic [CNT_W-1:0] count_n;
    logic             trig_q;
    logic             rise;
    logic             start;
    logic             ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            gcnt    <= '0;
            pulse   <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
            trig_q  <= 1'b1;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            gcnt    <= gcnt_n;
            pulse   <= pulse_n;
            overrun <= overrun_n;
            count   <= count_n;
            trig_q  <= trig;
        end
    end

    // The final cycle of HIGH (no gap) or GAP hands back to IDLE and may
    // accept a new edge in the same cycle, so back-to-back pulses keep the
    // minimum WIDTH+GAP spacing.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        gcnt_n  = gcnt;
        pulse_n = pulse;
        start   = 1'b0;
        ovr_set = 1'b0;
        rise    = trig & ~trig_q;

        unique case (state)
            S_IDLE: begin
                pulse_n = 1'b0;
                if (rise && en) start = 1'b1;
            end
            S_HIGH: begin
                if (wcnt == '0) begin
                    pulse_n = 1'b0;
                    if (HAS_GAP) begin
                        state_n = S_GAP;
                        gcnt_n  = GLOAD;
                        if (rise && en) ovr_set = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        if (rise && en) start = 1'b1;
                    end
                end else begin
                    wcnt_n = wcnt - 1'b1;
                    if (rise && en) ovr_set = 1'b1;
                end
            end
            S_GAP: begin
                pulse_n = 1'b0;
                if (gcnt == '0) begin
                    state_n = S_IDLE;
                    if (rise && en) start = 1'b1;
                end else begin
                    gcnt_n = gcnt - 1'b1;
                    if (rise && en) ovr_set = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                pulse_n = 1'b0;
            end
        endcase

        if (start) begin
            state_n = S_HIGH;
            pulse_n = 1'b1;
            wcnt_n  = WLOAD;
        end
    end

    // clr clears first; a start or overrun in the same cycle still lands.
    always_comb begin
        count_n = clr ? '0 : count;
        if (start) count_n = count_n + 1'b1;
        overrun_n = ovr_set | (overrun & ~clr);
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed bench for pulse_shaper: vector table plus hand-written
// sequences for reset, async reset mid-pulse and counter wrap.
module tb_pulse_shaper;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       trig;
    logic       clr;
    logic       pulse;
    logic       busy;
    logic       overrun;
    logic [7:0] count;
    logic       pulse2;
    logic       busy2;
    logic       overrun2;
    logic [1:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_shaper #(.WIDTH(5), .GAP(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .clr(clr),
        .pulse(pulse), .busy(busy), .overrun(overrun), .count(count)
    );

    pulse_shaper #(.WIDTH(5), .GAP(2), .CNT_W(2)) u_w2 (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .clr(clr),
        .pulse(pulse2), .busy(busy2), .overrun(overrun2), .count(count2)
    );

    typedef struct {
        logic       en;
        logic       trig;
        logic       clr;
        logic       p;
        logic       b;
        logic       o;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic t, input logic c,
                       input logic p, input logic b, input logic o,
                       input logic [7:0] cnt);
        vec_t v;
        v.en = e; v.trig = t; v.clr = c;
        v.p = p; v.b = b; v.o = o; v.c = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int hi;
        rst = 1'b1; en = 1'b1; trig = 1'b1; clr = 1'b0;

        // Reset held with trig high, release with trig still high
        repeat (3) @(negedge clk);
        check("reset_state", {pulse, busy, overrun, count}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_%0d", i),
                  {pulse, busy, overrun, count}, 32'h0);
        end

        // en trig clr | pulse busy ovr count
        add(1,0,0, 0,0,0,0);
        add(1,1,0, 1,1,0,1);
        add(1,1,0, 1,1,0,1);
        add(1,0,0, 1,1,0,1);
        add(1,1,0, 1,1,1,1);
        add(1,1,0, 1,1,1,1);
        add(1,0,0, 0,1,1,1);
        add(1,0,0, 0,1,1,1);
        add(1,1,0, 1,1,1,2);
        add(1,1,0, 1,1,1,2);
        add(1,1,0, 1,1,1,2);
        add(1,1,0, 1,1,1,2);
        add(1,1,0, 1,1,1,2);
        add(1,0,0, 0,1,1,2);
        add(1,0,0, 0,1,1,2);
        add(1,0,0, 0,0,1,2);
        add(1,1,1, 1,1,0,1);
        add(1,0,0, 1,1,0,1);
        add(1,1,1, 1,1,1,0);
        add(1,0,1, 1,1,0,0);
        add(1,0,0, 1,1,0,0);
        add(1,0,0, 0,1,0,0);
        add(1,0,0, 0,1,0,0);
        add(1,0,0, 0,0,0,0);
        add(0,1,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,1,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,1,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(1,1,0, 1,1,0,1);
        add(0,0,0, 1,1,0,1);
        add(0,1,0, 1,1,0,1);
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 1,1,0,1);
        add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,1,0,1);
        add(0,0,0, 0,0,0,1);

        foreach (vecs[i]) begin
            en = vecs[i].en; trig = vecs[i].trig; clr = vecs[i].clr;
            @(negedge clk);
            check($sformatf("vec_%0d", i),
                  {pulse, busy, overrun, count},
                  {vecs[i].p, vecs[i].b, vecs[i].o, vecs[i].c});
        end

        // Async reset two cycles into HIGH
        en = 1'b1; trig = 1'b1; clr = 1'b0;
        @(negedge clk);
        check("arst_started", {pulse, busy}, 2'b11);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_immediate", {pulse, busy, count}, 10'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_edge", {pulse, busy}, 2'b00);
        trig = 1'b0;
        @(negedge clk);
        trig = 1'b1;
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pulse) hi++;
        end
        check("arst_full_width", hi, 5);
        check("arst_count", count, 1);

        // Counter wrap on the 2-bit instance
        trig = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("wrap_clr", {count, 6'(count2)}, 14'h0);
        for (int p = 0; p < 5; p++) begin
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("wrap_count8", count, 5);
        check("wrap_count2", count2, 1);
        check("wrap_idle", {busy, busy2, overrun, overrun2}, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
